pm_spm_page_writer: RTL and testbench

//  Self-programming (SPM) engine that feeds the write port of the AVR program memory.

---
 rtl/pm_spm_page_writer.sv | 162 ++++++++++++++++
 tb/tb_pm_spm_page_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pm_spm_page_writer.sv
// SPM page writer: buffers CPU fill words, then commits a whole PM page (erase or write) one word per clock.
// Optional boot-section protection is enabled by defining PM_BOOT_PROTECT_EN.
module pm_spm_page_writer #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 13,
    parameter int PAGE_W    = 6,
    parameter int BOOT_PAGE = 120
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 spm_we_i,
    input  logic [1:0]           spm_op_i,
    input  logic [ADDR_W-1:0]    spm_addr_i,
    input  logic [WORD_SIZE-1:0] spm_data_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 pm_sel_o,
    output logic [ADDR_W-1:0]    pm_addr_o,
    output logic                 pm_we_o,
    output logic [WORD_SIZE-1:0] pm_data_o
);

    localparam int NWORDS = 1 << PAGE_W;
    localparam int PG_W   = ADDR_W - PAGE_W;
    localparam logic [PG_W-1:0] BOOT_PG = PG_W'(BOOT_PAGE);

`ifdef PM_BOOT_PROTECT_EN
    localparam bit PROTECT_EN = 1'b1;
`else
    localparam bit PROTECT_EN = 1'b0;
`endif

    localparam logic [1:0] OP_FILL  = 2'b00;
    localparam logic [1:0] OP_ERASE = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERASE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [WORD_SIZE-1:0]   pbuf_q [NWORDS];
    logic [NWORDS-1:0]      vld_q;
    logic [PAGE_W-1:0]      cnt_q;
    logic [PG_W-1:0]        page_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic                   sel_q;
    logic                   we_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [WORD_SIZE-1:0]   data_q;

    logic [PG_W-1:0]        req_page;
    logic [PAGE_W-1:0]      req_off;
    logic                   is_idle;
    logic                   fill_en;
    logic                   commit_req;
    logic                   prot_hit;
    logic [PAGE_W-1:0]      cnt_nxt;
    logic [WORD_SIZE-1:0]   rd_first;
    logic [WORD_SIZE-1:0]   rd_next;

    assign req_page   = spm_addr_i[ADDR_W-1:PAGE_W];
    assign req_off    = spm_addr_i[PAGE_W-1:0];
    assign is_idle    = (state_q == S_IDLE);
    assign fill_en    = spm_we_i && is_idle && (spm_op_i == OP_FILL);
    assign commit_req = spm_we_i && is_idle &&
                        ((spm_op_i == OP_ERASE) || (spm_op_i == OP_WRITE));
    assign prot_hit   = PROTECT_EN && (req_page >= BOOT_PG);
    assign cnt_nxt    = cnt_q + 1'b1;

    // Words never filled since the last write read back as erased flash.
    always_comb begin
        rd_first = '1;
        rd_next  = '1;
        if (vld_q[0])
            rd_first = pbuf_q[0];
        if (vld_q[cnt_nxt])
            rd_next = pbuf_q[cnt_nxt];
    end

    always_ff @(posedge clk_i) begin
        if (fill_en)
            pbuf_q[req_off] <= spm_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            vld_q   <= '0;
            cnt_q   <= '0;
            page_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fill_en) begin
                        vld_q[req_off] <= 1'b1;
                    end else if (commit_req) begin
                        if (prot_hit) begin
                            err_q <= 1'b1;
                        end else begin
                            page_q  <= req_page;
                            cnt_q   <= '0;
                            state_q <= (spm_op_i == OP_ERASE) ? S_ERASE : S_WRITE;
                            busy_q  <= 1'b1;
                            sel_q   <= 1'b1;
                            we_q    <= 1'b1;
                            addr_q  <= {req_page, {PAGE_W{1'b0}}};
                            data_q  <= (spm_op_i == OP_ERASE) ? '1 : rd_first;
                        end
                    end
                end
                S_ERASE, S_WRITE: begin
                    if (cnt_q == '1) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        sel_q   <= 1'b0;
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        data_q  <= '0;
                        done_q  <= 1'b1;
                        if (state_q == S_WRITE)
                            vld_q <= '0;
                    end else begin
                        cnt_q  <= cnt_nxt;
                        addr_q <= {page_q, cnt_nxt};
                        data_q <= (state_q == S_ERASE) ? '1 : rd_next;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign pm_sel_o  = sel_q;
    assign pm_we_o   = we_q;
    assign pm_addr_o = addr_q;
    assign pm_data_o = data_q;

endmodule

// File: tb/tb_pm_spm_page_writer.sv
// Bench for pm_spm_page_writer: directed page commits plus randomized fills/commits against a page-level model.
module tb_pm_spm_page_writer;

`ifdef PM_BOOT_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        spm_we_i;
    logic [1:0]  spm_op_i;
    logic [12:0] spm_addr_i;
    logic [15:0] spm_data_i;
    logic        busy_o, done_o, err_o, pm_sel_o, pm_we_o;
    logic [12:0] pm_addr_o;
    logic [15:0] pm_data_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] pm_mem  [8192];
    logic [15:0] exp_mem [8192];
    logic [15:0] mbuf [64];
    bit          mvld [64];

    pm_spm_page_writer dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .spm_we_i   (spm_we_i),
        .spm_op_i   (spm_op_i),
        .spm_addr_i (spm_addr_i),
        .spm_data_i (spm_data_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .pm_sel_o   (pm_sel_o),
        .pm_addr_o  (pm_addr_o),
        .pm_we_o    (pm_we_o),
        .pm_data_o  (pm_data_o)
    );

    always #5 clk_i = ~clk_i;

    // Program memory seen by the DUT: one word per cycle where the write enable is held.
    always @(negedge clk_i) begin
        if (pm_we_o)
            pm_mem[pm_addr_o] <= pm_data_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fill(input logic [5:0] off, input logic [15:0] d);
        @(negedge clk_i);
        spm_we_i   = 1'b1;
        spm_op_i   = 2'b00;
        spm_addr_i = {7'($urandom), off};
        spm_data_i = d;
        @(negedge clk_i);
        spm_we_i = 1'b0;
        check("fill_busy", 32'(busy_o), 32'd0);
        mvld[off] = 1'b1;
        mbuf[off] = d;
    endtask

    task automatic noop(input logic [12:0] addr);
        logic acc;
        acc = 1'b0;
        @(negedge clk_i);
        spm_we_i   = 1'b1;
        spm_op_i   = 2'b11;
        spm_addr_i = addr;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            if (k == 1) spm_we_i = 1'b0;
            acc = acc | busy_o | pm_we_o | pm_sel_o | done_o | err_o;
        end
        check("noop_quiet", 32'(acc), 32'd0);
    endtask

    // Commit of a whole page; op 01 erase, 10 write. Optionally strobes a fill mid-commit.
    task automatic commit(input logic [1:0] op, input logic [12:0] addr, input bit inject);
        logic [12:0] base;
        logic [15:0] ed [64];
        bit          prot;
        int we_cnt, busy_cnt, done_cnt, done_k, err_cnt, err_k, first_we, last_we;
        base = {addr[12:6], 6'd0};
        prot = PROT && (addr[12:6] >= 7'd120);
        for (int i = 0; i < 64; i++)
            ed[i] = (op == 2'b01) ? 16'hFFFF : (mvld[i] ? mbuf[i] : 16'hFFFF);
        we_cnt = 0; busy_cnt = 0; done_cnt = 0; done_k = 0;
        err_cnt = 0; err_k = 0; first_we = 0; last_we = 0;
        @(negedge clk_i);
        spm_we_i   = 1'b1;
        spm_op_i   = op;
        spm_addr_i = addr;
        spm_data_i = 16'($urandom);
        for (int k = 1; k <= 67; k++) begin
            @(negedge clk_i);
            if (k == 1) spm_we_i = 1'b0;
            if (pm_we_o) begin
                check("wr_addr", 32'(pm_addr_o), 32'(base + 13'(we_cnt)));
                check("wr_data", 32'(pm_data_o), 32'(ed[we_cnt & 63]));
                check("wr_sel", 32'(pm_sel_o), 32'd1);
                if (first_we == 0) first_we = k;
                last_we = k;
                we_cnt++;
            end
            if (busy_o) busy_cnt++;
            if (done_o) begin done_cnt++; done_k = k; end
            if (err_o) begin err_cnt++; err_k = k; end
            if (inject && k == 20) begin
                spm_we_i   = 1'b1;
                spm_op_i   = 2'b00;
                spm_addr_i = 13'($urandom);
                spm_data_i = 16'($urandom);
            end
            if (inject && k == 21) spm_we_i = 1'b0;
        end
        check("we_count",   32'(we_cnt),   prot ? 32'd0 : 32'd64);
        check("busy_count", 32'(busy_cnt), prot ? 32'd0 : 32'd64);
        check("first_we",   32'(first_we), prot ? 32'd0 : 32'd1);
        check("last_we",    32'(last_we),  prot ? 32'd0 : 32'd64);
        check("done_count", 32'(done_cnt), prot ? 32'd0 : 32'd1);
        check("done_cycle", 32'(done_k),   prot ? 32'd0 : 32'd65);
        check("err_count",  32'(err_cnt),  prot ? 32'd1 : 32'd0);
        check("err_cycle",  32'(err_k),    prot ? 32'd1 : 32'd0);
        if (!prot) begin
            for (int i = 0; i < 64; i++) exp_mem[base + 13'(i)] = ed[i];
            if (op == 2'b10)
                for (int i = 0; i < 64; i++) mvld[i] = 1'b0;
        end
        for (int i = 0; i < 64; i++)
            check("page_img", 32'(pm_mem[base + 13'(i)]), 32'(exp_mem[base + 13'(i)]));
    endtask

    initial begin
        logic acc;
        logic [12:0] raddr;
        int nf;
        for (int i = 0; i < 8192; i++) begin pm_mem[i] = 16'h0; exp_mem[i] = 16'h0; end
        for (int i = 0; i < 64; i++) begin mbuf[i] = 16'h0; mvld[i] = 1'b0; end
        rst_i = 1'b1; spm_we_i = 1'b0; spm_op_i = 2'b00; spm_addr_i = '0; spm_data_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_pm_addr", 32'(pm_addr_o), 32'd0);
        check("rst_pm_data", 32'(pm_data_o), 32'd0);
        rst_i = 1'b0;

        // Idle after reset: nothing may stir.
        acc = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            acc = acc | busy_o | pm_we_o | pm_sel_o | done_o | err_o;
        end
        check("idle_quiet", 32'(acc), 32'd0);

        // Full page write at 0x40.
        for (int i = 0; i < 64; i++) fill(6'(i), 16'hA000 + 16'(i));
        commit(2'b10, 13'h0040, 1'b0);
        check("t2_first", 32'(pm_mem[13'h40]), 32'hA000);
        check("t2_last",  32'(pm_mem[13'h7F]), 32'hA03F);

        // Sparse buffer: one valid word, rest reads as erased.
        fill(6'd5, 16'h1234);
        commit(2'b10, 13'h0080, 1'b0);
        check("t3_word5", 32'(pm_mem[13'h85]), 32'h1234);
        check("t3_word0", 32'(pm_mem[13'h80]), 32'hFFFF);
        commit(2'b10, 13'h00C0, 1'b0);
        check("t3_cleared", 32'(pm_mem[13'hC5]), 32'hFFFF);

        // Erase with a fill strobe mid-commit that must be dropped.
        commit(2'b01, 13'h0123, 1'b1);
        commit(2'b10, 13'h0140, 1'b0);

        // Reset during the 10th write cycle.
        for (int i = 0; i < 64; i++) fill(6'(i), 16'($urandom));
        @(negedge clk_i);
        spm_we_i = 1'b1; spm_op_i = 2'b10; spm_addr_i = 13'h0280;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_i);
            if (k == 1) spm_we_i = 1'b0;
            check("t5_we_on", 32'(pm_we_o), 32'd1);
        end
        @(posedge clk_i);
        #1;
        check("t5_pre_rst", 32'(pm_addr_o), 32'h0289);
        rst_i = 1'b1;
        #1;
        check("t5_rst_we",   32'(pm_we_o),  32'd0);
        check("t5_rst_sel",  32'(pm_sel_o), 32'd0);
        check("t5_rst_busy", 32'(busy_o),   32'd0);
        for (int i = 0; i < 9; i++) exp_mem[13'h0280 + 13'(i)] = mbuf[i];
        for (int i = 0; i < 64; i++) mvld[i] = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        for (int i = 0; i < 64; i++)
            check("t5_page", 32'(pm_mem[13'h0280 + 13'(i)]), 32'(exp_mem[13'h0280 + 13'(i)]));
        commit(2'b10, 13'h02C0, 1'b0);

        // Boot page boundary.
        fill(6'd3, 16'hBEEF);
        commit(2'b10, 13'h1E00, 1'b0);
        commit(2'b10, 13'h1DC0, 1'b0);

        // Randomized fills and commits.
        for (int r = 0; r < 8; r++) begin
            nf = $urandom_range(0, 20);
            for (int f = 0; f < nf; f++) fill(6'($urandom), 16'($urandom));
            raddr = 13'($urandom);
            case ($urandom_range(1, 3))
                1: commit(2'b01, raddr, 1'($urandom));
                2: commit(2'b10, raddr, 1'($urandom));
                default: noop(raddr);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
